// File: rtl/frame_pixel_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Package : img_pkg
// Frame geometry, pixel and frame types and the FSM state type.
// Shared by the frame filters, this serializer and their benches.
// Revision: 1.0  initial release
// ============================================================================
package img_pkg;

  localparam int R_I = 5;
  localparam int C_I = 5;
  localparam int W_I = 8;

  // A 1-row or 1-column frame still gets a 1-bit counter.
  localparam int ROW_W = (R_I > 1) ? $clog2(R_I) : 1;
  localparam int COL_W = (C_I > 1) ? $clog2(C_I) : 1;

  typedef logic unsigned [W_I-1:0] pixel_t;
  typedef pixel_t [R_I-1:0][C_I-1:0] img_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_pixel_serializer_if.sv
`default_nettype none
// ============================================================================
// Interface : frame_pixel_serializer_if
// Pixel stream with valid/ready handshake and raster position flags.
// Revision: 1.0  initial release
// ============================================================================
interface frame_pixel_serializer_if;
  import img_pkg::*;

  pixel_t pix_data;
  logic   pix_valid;
  logic   pix_ready;
  logic   pix_sof;
  logic   pix_eol;
  logic   pix_eof;

  modport master (
    output pix_data,
    output pix_valid,
    output pix_sof,
    output pix_eol,
    output pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    input  pix_sof,
    input  pix_eol,
    input  pix_eof,
    output pix_ready
  );

endinterface
`default_nettype wire

// File: rtl/frame_pixel_serializer_raster_counter.sv
`default_nettype none
// ============================================================================
// Module  : raster_counter
// Row/column position counter walking a frame in raster order.
// Revision: 1.0  initial release
// ============================================================================
module raster_counter #(
  parameter  int R_I   = 5,
  parameter  int C_I   = 5,
  localparam int ROW_W = (R_I > 1) ? $clog2(R_I) : 1,
  localparam int COL_W = (C_I > 1) ? $clog2(C_I) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cen,
  input  logic             clear,
  input  logic             step,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last_col,
  output logic             last
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  assign row      = row_q;
  assign col      = col_q;
  assign last_col = (col_q == COL_W'(C_I - 1));
  assign last     = last_col && (row_q == ROW_W'(R_I - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (step) begin
      if (last_col) begin
        col_d = '0;
        // Stepping past the final pixel wraps back to the frame origin.
        row_d = last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_q <= '0;
      col_q <= '0;
    end else if (cen) begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_pixel_serializer.sv
`default_nettype none
// ============================================================================
// Module  : frame_pixel_serializer
// Loads a whole frame in parallel and streams it out one pixel per transfer.
// Revision: 1.0  initial release
// ============================================================================
module frame_pixel_serializer
  import img_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cen,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  input  img_t                     img,
  frame_pixel_serializer_if.master pix,
  output logic                     busy,
  output logic                     overrun
);

  state_t           state_q, state_d;
  img_t             frame_q, frame_d;
  logic             frame_ready_q, frame_ready_d;
  logic             overrun_q, overrun_d;

  logic             accept;
  logic             xfer;
  logic             cnt_clear;
  logic             cnt_step;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last_col;
  logic             last;

  raster_counter #(
    .R_I (R_I),
    .C_I (C_I)
  ) u_raster_counter (
    .clk      (clk),
    .rstn     (rstn),
    .cen      (cen),
    .clear    (cnt_clear),
    .step     (cnt_step),
    .row      (row),
    .col      (col),
    .last_col (last_col),
    .last     (last)
  );

  // cen gating lives in the flops, so these only describe intent.
  assign accept = frame_valid && frame_ready_q;
  assign xfer   = pix.pix_valid && pix.pix_ready;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    overrun_d = overrun_q | (frame_valid && busy);
    cnt_clear = 1'b0;
    cnt_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = STREAM;
          frame_d   = img;
          cnt_clear = 1'b1;
        end
      end
      STREAM: begin
        cnt_step = xfer;
        if (xfer && last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    frame_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      frame_ready_q <= 1'b1;
      overrun_q     <= 1'b0;
    end else if (cen) begin
      state_q       <= state_d;
      frame_ready_q <= frame_ready_d;
      overrun_q     <= overrun_d;
    end
  end

  // Frame storage is deliberately not reset; it is only read while streaming.
  always_ff @(posedge clk) begin
    if (rstn && cen) begin
      frame_q <= frame_d;
    end
  end

  assign frame_ready   = frame_ready_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q == STREAM);

  assign pix.pix_valid = busy;
  assign pix.pix_data  = busy ? frame_q[row][col] : '0;
  assign pix.pix_sof   = busy && (row == '0) && (col == '0);
  assign pix.pix_eol   = busy && last_col;
  assign pix.pix_eof   = busy && last;

endmodule
`default_nettype wire
